// File: rtl/pck_hdr_addr_unit.sv
// Header-flit builder and endpoint address helper for a 2D-mesh NoC endpoint.
// Produces header flit, linear src/dest IDs, hop distance and a range flag, one cycle after in_valid.
module pck_hdr_addr_unit #(
  parameter int T1      = 4,
  parameter int T2      = 4,
  parameter int T3      = 1,
  parameter int V       = 2,
  parameter int C       = 2,
  parameter int WEIGHTw = 4,
  parameter int DSTPw   = 4,
  parameter int BEw     = 1,
  parameter int Fpay    = 32,
  localparam int Cw     = (C  > 2) ? $clog2(C)  : 1,
  localparam int Xw     = (T1 > 2) ? $clog2(T1) : 1,
  localparam int Yw     = (T2 > 2) ? $clog2(T2) : 1,
  localparam int Lw     = (T3 > 2) ? $clog2(T3) : 1,
  localparam int EAw    = Xw + Yw + Lw,
  localparam int NE     = T1 * T2 * T3,
  localparam int NEw    = (NE > 2) ? $clog2(NE) : 1,
  localparam int DISTw  = $clog2(T1 + T2),
  localparam int DATA_w = Fpay - (2 * EAw + DSTPw + Cw + WEIGHTw + BEw),
  localparam int Fw     = 2 + V + Fpay
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [V-1:0]       vc_in,
  input  logic [Cw-1:0]      class_in,
  input  logic [EAw-1:0]     dest_e_addr_in,
  input  logic [EAw-1:0]     src_e_addr_in,
  input  logic [WEIGHTw-1:0] weight_in,
  input  logic [DSTPw-1:0]   destport_in,
  input  logic [DATA_w-1:0]  data_in,
  input  logic [BEw-1:0]     be_in,
  input  logic               single_in,
  output logic               out_valid,
  output logic [Fw-1:0]      flit_out,
  output logic [NEw-1:0]     src_id,
  output logic [NEw-1:0]     dest_id,
  output logic [DISTw-1:0]   distance,
  output logic               addr_err
);

  if (DATA_w < 1) begin : g_bad_width
    $error("pck_hdr_addr_unit: Fpay too small for header fields");
  end

  localparam logic [Xw:0]  T1_L = T1[Xw:0];
  localparam logic [Yw:0]  T2_L = T2[Yw:0];
  localparam logic [Lw:0]  T3_L = T3[Lw:0];
  localparam logic [31:0]  T1_U = 32'(T1);
  localparam logic [31:0]  T3_U = 32'(T3);

  // Index 0 decodes the source address, index 1 the destination.
  logic [EAw-1:0] addr   [2];
  logic [Xw-1:0]  x_f    [2];
  logic [Yw-1:0]  y_f    [2];
  logic [NEw-1:0] id_f   [2];
  logic           err_f  [2];

  assign addr[0] = src_e_addr_in;
  assign addr[1] = dest_e_addr_in;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_decode
      logic [Lw-1:0] l_f;
      logic [31:0]   id_full;
      assign x_f[gi]   = addr[gi][Xw-1:0];
      assign y_f[gi]   = addr[gi][Xw+Yw-1:Xw];
      assign l_f       = addr[gi][EAw-1:Xw+Yw];
      assign err_f[gi] = ({1'b0, x_f[gi]} >= T1_L) || ({1'b0, y_f[gi]} >= T2_L) ||
                         ({1'b0, l_f} >= T3_L);
      assign id_full   = (32'(y_f[gi]) * T1_U + 32'(x_f[gi])) * T3_U + 32'(l_f);
      assign id_f[gi]  = err_f[gi] ? '0 : id_full[NEw-1:0];
    end
  endgenerate

  logic [Xw:0]      dx;
  logic [Yw:0]      dy;
  logic [31:0]      dist_full;
  logic [Fpay-1:0]  payload;

  assign dx = (x_f[0] >= x_f[1]) ? ({1'b0, x_f[0]} - {1'b0, x_f[1]})
                                 : ({1'b0, x_f[1]} - {1'b0, x_f[0]});
  assign dy = (y_f[0] >= y_f[1]) ? ({1'b0, y_f[0]} - {1'b0, y_f[1]})
                                 : ({1'b0, y_f[1]} - {1'b0, y_f[0]});
  assign dist_full = 32'(dx) + 32'(dy) + 32'd1;

  // LSB first: src, dest, destport, class, weight, be, data on top.
  assign payload = {data_in, be_in, weight_in, class_in, destport_in,
                    dest_e_addr_in, src_e_addr_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      flit_out  <= '0;
      src_id    <= '0;
      dest_id   <= '0;
      distance  <= '0;
      addr_err  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        flit_out  <= {1'b1, single_in, vc_in, payload};
        src_id    <= id_f[0];
        dest_id   <= id_f[1];
        distance  <= dist_full[DISTw-1:0];
        addr_err  <= err_f[0] | err_f[1];
      end
    end
  end

endmodule

// File: tb/tb_pck_hdr_addr_unit.sv
// Randomized self-checking bench for pck_hdr_addr_unit (4x4 mesh, one endpoint per router).
// Expectations come from an arithmetic model of the address/header rules.
module tb_pck_hdr_addr_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  vc_in = '0;
  logic [0:0]  class_in = '0;
  logic [4:0]  dest_e_addr_in = '0;
  logic [4:0]  src_e_addr_in = '0;
  logic [3:0]  weight_in = '0;
  logic [3:0]  destport_in = '0;
  logic [11:0] data_in = '0;
  logic [0:0]  be_in = '0;
  logic        single_in = 1'b0;
  logic        out_valid;
  logic [35:0] flit_out;
  logic [3:0]  src_id;
  logic [3:0]  dest_id;
  logic [2:0]  distance;
  logic        addr_err;

  int checks_total = 0;
  int checks_passed = 0;

  // Reference model state: what the outputs should show after the last edge.
  logic        m_valid = 1'b0;
  longint      m_flit = 0;
  int          m_src_id = 0;
  int          m_dest_id = 0;
  int          m_dist = 0;
  int          m_err = 0;

  always #5 clk = ~clk;

  pck_hdr_addr_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .vc_in(vc_in),
    .class_in(class_in), .dest_e_addr_in(dest_e_addr_in),
    .src_e_addr_in(src_e_addr_in), .weight_in(weight_in),
    .destport_in(destport_in), .data_in(data_in), .be_in(be_in),
    .single_in(single_in), .out_valid(out_valid), .flit_out(flit_out),
    .src_id(src_id), .dest_id(dest_id), .distance(distance), .addr_err(addr_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Mesh coordinates of an endpoint address: 2 bits x, 2 bits y, 1 bit l.
  function automatic int ax(input int a); return a % 4;       endfunction
  function automatic int ay(input int a); return (a / 4) % 4; endfunction
  function automatic int al(input int a); return a / 16;      endfunction

  function automatic bit bad_addr(input int a);
    return (ax(a) >= 4) || (ay(a) >= 4) || (al(a) >= 1);
  endfunction

  function automatic int lin_id(input int a);
    return bad_addr(a) ? 0 : (ay(a) * 4 + ax(a)) * 1 + al(a);
  endfunction

  task automatic model_update();
    int s, d;
    m_valid = in_valid;
    if (in_valid) begin
      s = int'(src_e_addr_in);
      d = int'(dest_e_addr_in);
      m_flit = longint'(s) + longint'(d) * 32 + longint'(destport_in) * 1024
             + longint'(class_in) * (1 << 14) + longint'(weight_in) * (1 << 15)
             + longint'(be_in) * (1 << 19) + longint'(data_in) * (1 << 20)
             + longint'(vc_in) * (64'd1 << 32) + longint'(single_in) * (64'd1 << 34)
             + (64'd1 << 35);
      m_src_id  = lin_id(s);
      m_dest_id = lin_id(d);
      m_dist    = (abs_i(ax(s) - ax(d)) + abs_i(ay(s) - ay(d)) + 1) % 8;
      m_err     = (bad_addr(s) || bad_addr(d)) ? 1 : 0;
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".valid"},   64'(out_valid), 64'(m_valid));
    check_val({tag, ".flit"},    64'(flit_out),  64'(m_flit));
    check_val({tag, ".src_id"},  64'(src_id),    64'(m_src_id));
    check_val({tag, ".dest_id"}, 64'(dest_id),   64'(m_dest_id));
    check_val({tag, ".dist"},    64'(distance),  64'(m_dist));
    check_val({tag, ".err"},     64'(addr_err),  64'(m_err));
  endtask

  // One clock: model captures, then outputs are sampled just after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_update();
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [4:0] src, input logic [4:0] dst,
                       input logic [1:0] vc, input logic cls, input logic [3:0] w,
                       input logic [3:0] dp, input logic [11:0] d, input logic be,
                       input logic s);
    in_valid = v; src_e_addr_in = src; dest_e_addr_in = dst; vc_in = vc;
    class_in = cls; weight_in = w; destport_in = dp; data_in = d; be_in = be;
    single_in = s;
  endtask

  initial begin
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed header example.
    drive(1'b1, 5'h00, 5'h0B, 2'b01, 1'b1, 4'h3, 4'h5, 12'hABC, 1'b1 == 1'b0, 1'b0);
    be_in = 1'b1;
    step("hdr");
    check_val("hdr.payload_const", 64'(flit_out), 64'h9_ABC9_D560);
    check_val("hdr.top4", 64'(flit_out[35:32]), 64'h9);
    check_val("hdr.dist6", 64'(distance), 64'd6);

    single_in = 1'b1;
    step("single");
    check_val("single.tail", 64'(flit_out[34]), 64'd1);

    drive(1'b1, 5'h05, 5'h05, 2'b10, 1'b0, 4'h1, 4'h2, 12'h123, 1'b0, 1'b0);
    step("same");
    check_val("same.dist1", 64'(distance), 64'd1);

    drive(1'b1, 5'h10, 5'h0B, 2'b01, 1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 1'b0);
    step("oor");
    check_val("oor.err", 64'(addr_err), 64'd1);
    check_val("oor.dest_id", 64'(dest_id), 64'd11);

    // One-cycle pulse then idle: outputs hold.
    drive(1'b1, 5'h0F, 5'h00, 2'b11, 1'b1, 4'hF, 4'hF, 12'hFFF, 1'b1, 1'b1);
    step("pulse");
    in_valid = 1'b0;
    src_e_addr_in = 5'h03;
    for (int i = 0; i < 3; i++) step("idle");

    // Asynchronous reset between edges, mid-stream.
    drive(1'b1, 5'h06, 5'h09, 2'b01, 1'b0, 4'h7, 4'h3, 12'h5A5, 1'b1, 1'b0);
    step("pre_rst");
    #2;
    reset = 1'b1;
    #1;
    m_valid = 1'b0; m_flit = 0; m_src_id = 0; m_dest_id = 0; m_dist = 0; m_err = 0;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    step("post_rst_idle");
    in_valid = 1'b1;
    step("post_rst_first");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom), 2'($urandom),
            1'($urandom), 4'($urandom), 4'($urandom), 12'($urandom), 1'($urandom),
            1'($urandom));
      if ($urandom_range(0, 1) == 1) src_e_addr_in[4] = 1'b0;
      if ($urandom_range(0, 1) == 1) dest_e_addr_in[4] = 1'b0;
      step("rand");
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/pck_hdr_addr_unit.md
Name: pck_hdr_addr_unit

Overview:
- Endpoint-side header and address helper for a 2D-mesh NoC.
- From per-packet fields it builds the header flit, decodes the source and destination endpoint addresses to linear IDs, and computes the router-hop distance between them.
- All three results are registered together with one cycle of latency.
- It sits between a packet injector/ejector and the NoC channel.

Parameters:
- T1, 4: mesh columns (NX).
- T2, 4: mesh rows (NY).
- T3, 1: endpoints per router (NL).
- V, 2: virtual channels; VC field is one-hot.
- C, 2: message classes; Cw = max(1, log2(C)).
- WEIGHTw, 4: weight field width.
- DSTPw, 4: destport field width.
- BEw, 1: byte-enable field width.
- Fpay, 32: flit payload width.
- Derived widths:
  - Xw = max(1, log2(T1)); Yw = max(1, log2(T2)); Lw = max(1, log2(T3)).
  - EAw = Xw + Yw + Lw.
  - NE = T1*T2*T3; NEw = max(1, log2(NE)).
  - DISTw = log2(T1+T2).
  - DATA_w = Fpay - (2*EAw + DSTPw + Cw + WEIGHTw + BEw); must be ≥ 1, else elaboration error.
  - Fw = 2 + V + Fpay.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: capture the input fields this cycle.
- vc_in, input, V: one-hot VC.
- class_in, input, Cw: message class.
- dest_e_addr_in, input, EAw: destination endpoint address.
- src_e_addr_in, input, EAw: source endpoint address.
- weight_in, input, WEIGHTw: initial weight.
- destport_in, input, DSTPw: precomputed destination port.
- data_in, input, DATA_w: header payload data.
- be_in, input, BEw: byte enable.
- single_in, input, 1: packet is a single flit (header is also the tail).
- out_valid, output, 1: outputs updated last cycle.
- flit_out, output, Fw: header flit.
- src_id, output, NEw: linear ID of the source.
- dest_id, output, NEw: linear ID of the destination.
- distance, output, DISTw: routers traversed.
- addr_err, output, 1: an input address was out of range.

Behaviour:
- Address format, LSB first: x = addr[Xw-1:0], y = addr[Xw+Yw-1:Xw], l = addr[EAw-1:Xw+Yw].
- Linear ID: id = (y*T1 + x)*T3 + l.
- Distance: |xs-xd| + |ys-yd| + 1. When src == dest, distance = 1.
- Header payload, packed LSB first:
  - src_e_addr, then dest_e_addr, destport, class, weight, be, data.
  - The data field occupies the top DATA_w bits.
- flit_out = {hdr_flag=1, tail_flag=single_in, vc_in, payload}, with hdr_flag at the MSB and vc directly above the payload.
- Range check: addr_err = 1 if either address has x ≥ T1, y ≥ T2, or l ≥ T3.
  - When an address is out of range, its ID output is forced to 0.
  - distance is still computed from the raw fields, truncated to DISTw.
- Timing:
  - All output registers load on a clk edge where in_valid = 1.
  - out_valid <= in_valid every cycle.
  - Latency is exactly one cycle; throughput is one request per cycle.
- When in_valid = 0: flit_out, src_id, dest_id, distance and addr_err hold their last values; out_valid = 0.
- Reset (asynchronous, any time, including mid-stream): every output goes to 0, including flit_out and out_valid. The first valid output appears one cycle after the first in_valid following reset release.
- No legality checks on the remaining fields:
  - vc_in need not be one-hot; it is passed through unchanged.
  - class_in ≥ C is passed through unchanged.
- Field arithmetic is unsigned. Absolute differences are computed at Xw+1 / Yw+1 bits before summing.

Test Plan:
- 4x4, T3=1: src=0x00 (x0,y0), dest=0x0B (x3,y2), vc=2'b01, class=1, weight=4'h3, destport=4'h5, be=1, data=12'hABC, single=0.
  - Next cycle: out_valid=1, src_id=0, dest_id=11, distance=6, addr_err=0.
  - payload = 0xABC_1_3_1_5_0B_00, bit-exact per the LSB-first packing.
  - flit_out[35:32] = 4'b1001.
- Same fields with single_in=1 → tail_flag=1 (flit_out[34]=1); other bits unchanged.
- src=dest=0x05 (x1,y1) → src_id=dest_id=5, distance=1.
- src=0x10 (l=1 while T3=1) → addr_err=1, src_id=0; dest_id computed normally.
- in_valid pulsed for 1 cycle, then held low 3 cycles → out_valid high for exactly 1 cycle; the other outputs hold.
- Assert reset asynchronously mid-stream between clk edges → all outputs go to 0 immediately. After release, the first in_valid produces out_valid one cycle later.
